frac_baud_gen: RTL
==================

// Module: frac_baud_gen
// PURPOSE
//  Programmable fractional-N baud tick generator for the UART. Replaces fixed 4-entry divisor selection.
//  Runtime divisor = DIV_INT + DIV_FRAC/2^FracWidth clock cycles per oversample tick. Emits an oversample
//  tick (rx sampling) and a 1x bit tick (tx shifting). Divisor changes are shadowed; they apply only when both UART paths are idle.
// PARAMETERS
//  ClockFrequency  50_000_000  system clock in Hz; used only for reset divisor
//  OverSampleRate  16          oversample ticks per bit tick; >=2
//  IntWidth        16          width of integer divisor
//  FracWidth       4           width of fractional divisor; 0 disallowed
//  ResetBaud       115200      baud rate the reset divisor is computed from
// PORTS
//  clk_i         in   1          clock
//  rst_i         in   1          synchronous active-high reset
//  en_i          in   1          generator enable
//  rx_busy_i     in   1          receiver mid-frame
//  tx_busy_i     in   1          transmitter mid-frame
//  div_wr_i      in   1          1-cycle strobe: load div_int_i/div_frac_i into shadow
//  div_int_i     in   IntWidth   requested integer divisor
//  div_frac_i    in   FracWidth  requested fractional divisor
//  os_tick_o     out  1          1-cycle oversample tick
//  bit_tick_o    out  1          1-cycle bit tick; coincides with every OverSampleRate-th os_tick_o
//  div_pending_o out  1          shadow divisor waiting to apply
//  div_int_o     out  IntWidth   active integer divisor
//  div_frac_o    out  FracWidth  active fractional divisor
// BEHAVIOUR
//  Reset values:
//   - all counters, frac accumulator, pending, os_tick_o, bit_tick_o = 0
//   - active and shadow divisor = uart_pkg::calc_div(ClockFrequency, ResetBaud, OverSampleRate)
//  Ticks are registered outputs: asserted the cycle after the terminal count is reached.
//  Period engine, with en_i=1 and no apply pending-this-cycle:
//   - cyc_cnt counts 0..lim-1; lim = div_int + carry
//   - on wrap: acc <= acc + div_frac (FracWidth bits); carry for the next period = adder carry-out
//   - os_tick_o pulses once per wrap; os_cnt counts 0..OverSampleRate-1
//   - bit_tick_o pulses with the os tick that wraps os_cnt
//   - mean os period over 2^FracWidth ticks = div_int*2^FracWidth + div_frac cycles exactly
//  Clamp: active div_int < 2 is treated as 2. div_int=2, frac=0 gives os_tick every 2nd cycle.
//  en_i=0: cyc_cnt, os_cnt, acc are held at 0; no ticks. First os tick comes lim cycles after en_i rises.
//  Divisor write:
//   - div_wr_i=1: shadow <= inputs, pending <= 1
//   - later writes before apply overwrite the shadow (last-write-wins)
//  Apply condition: pending && !(rx_busy_i || tx_busy_i), evaluated on registered pending. On apply:
//   - active <= shadow; pending <= 0
//   - cyc_cnt, os_cnt, acc <= 0; no tick issued that cycle
//  Simultaneous div_wr_i and apply: old shadow applies; the new value loads the shadow; pending stays 1.
//  Busy asserted: active divisor is frozen; counting continues uninterrupted, so frame timing is never disturbed.
//  Reset mid-frame discards counters and the pending write.
// STRUCTURE
//  uart_pkg:
//   - BAUD_*_RATE constants
//   - typedef baud_div_t {int, frac}
//   - function calc_div(clk, baud, osr): rounds to nearest 1/2^FracWidth
//  Sub-module frac_accum: holds acc and carry, advanced by a wrap strobe.
//  Top level holds shadow/apply logic, cyc_cnt, os_cnt and output registers.
// TESTING
//  Reset defaults: 50 MHz, ResetBaud 115200 -> div_int_o=27, div_frac_o=2, 
//   os ticks 27/28 cycles apart, 16 ticks in 434 cycles.
//  Integer divisor: write int=10, frac=0 while idle -> applied next cycle, os_tick every 10 cycles,
//   bit_tick every 160 cycles.
//  Fraction: int=4, frac=8 -> os periods alternate 4 and 5 cycles (4,5,4,5...).
//  Busy hold: tx_busy_i=1, write int=6 -> div_pending_o=1, old rate kept. Busy drops -> applied next cycle, counters zeroed.
//  Last-write-wins: writes int=8 then int=12 while busy -> only 12 applied. Write on the apply cycle -> pending stays 1.
//  Clamp/enable:
//   - int=0 or 1 -> os_tick every 2 cycles
//   - en_i=0 for 50 cycles -> no ticks; re-enable -> first tick after lim cycles
//   - rst_i mid-frame -> outputs 0, reset divisor restored

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions: standard baud rates, the divisor record type and
//   calc_div(), which turns a clock/baud/oversample triple into a fixed-point
//   divisor rounded to the nearest 1/2^frac_w clock cycle.
package uart_pkg;

  localparam int unsigned BAUD_9600_RATE   = 9600;
  localparam int unsigned BAUD_19200_RATE  = 19200;
  localparam int unsigned BAUD_57600_RATE  = 57600;
  localparam int unsigned BAUD_115200_RATE = 115200;

  localparam int unsigned DIV_INT_W  = 16;
  localparam int unsigned DIV_FRAC_W = 4;

  typedef struct packed {
    logic [DIV_INT_W-1:0]  div_int;
    logic [DIV_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // Returns round(clk_hz * 2^frac_w / (baud * osr)). The caller splits the
  // result: upper bits are the integer divisor, low frac_w bits the fraction.
  function automatic longint unsigned calc_div(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned osr,
    input int unsigned     frac_w = DIV_FRAC_W
  );
    longint unsigned num;
    longint unsigned den;
    num = clk_hz << frac_w;
    den = baud * osr;
    return (num + (den >> 1)) / den;
  endfunction

endpackage

// File: rtl/frac_accum.sv
// frac_accum
//   Fractional phase accumulator. On every period wrap the fractional divisor
//   is added into acc; the adder carry-out lengthens the following period by
//   one clock.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   clr_i    synchronous clear (divisor apply or generator disabled)
//   wrap_i   one-cycle strobe: the period counter wrapped this cycle
//   frac_i   active fractional divisor
//   carry_o  1 when the current period is one clock longer
module frac_accum #(
  parameter int unsigned FracWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 wrap_i,
  input  logic [FracWidth-1:0] frac_i,
  output logic                 carry_o
);

  logic [FracWidth-1:0] acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic [FracWidth:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, frac_i};

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clr_i) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (wrap_i) begin
      acc_d   = sum[FracWidth-1:0];
      carry_d = sum[FracWidth];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign carry_o = carry_q;

endmodule

// File: rtl/frac_baud_gen.sv
// frac_baud_gen
//   Fractional-N baud tick generator. The oversample period averages
//   div_int + div_frac/2^FracWidth clocks; every OverSampleRate-th oversample
//   tick is also a bit tick. New divisors are written into a shadow register
//   and only take effect when neither the receiver nor the transmitter is busy.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_i                  generator enable (counters held at zero when low)
//   rx_busy_i, tx_busy_i  UART paths mid-frame; block divisor apply
//   div_wr_i              strobe loading div_int_i/div_frac_i into the shadow
//   os_tick_o, bit_tick_o registered one-cycle ticks
//   div_pending_o         shadow divisor waiting to apply
//   div_int_o, div_frac_o active divisor
module frac_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned OverSampleRate = 16,
  parameter int unsigned IntWidth       = 16,
  parameter int unsigned FracWidth      = 4,
  parameter int unsigned ResetBaud      = 115200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 rx_busy_i,
  input  logic                 tx_busy_i,
  input  logic                 div_wr_i,
  input  logic [IntWidth-1:0]  div_int_i,
  input  logic [FracWidth-1:0] div_frac_i,
  output logic                 os_tick_o,
  output logic                 bit_tick_o,
  output logic                 div_pending_o,
  output logic [IntWidth-1:0]  div_int_o,
  output logic [FracWidth-1:0] div_frac_o
);

  localparam longint unsigned RstDiv = calc_div(longint'(ClockFrequency),
                                                longint'(ResetBaud),
                                                longint'(OverSampleRate),
                                                FracWidth);
  localparam logic [IntWidth-1:0]  RstInt  = IntWidth'(RstDiv >> FracWidth);
  localparam logic [FracWidth-1:0] RstFrac = FracWidth'(RstDiv);

  localparam int unsigned CntW = IntWidth + 1;
  localparam int unsigned OsW  = $clog2(OverSampleRate);
  localparam logic [OsW-1:0] OsLast = OsW'(OverSampleRate - 1);

  logic [IntWidth-1:0]  act_int_q, act_int_d, shd_int_q, shd_int_d;
  logic [FracWidth-1:0] act_frac_q, act_frac_d, shd_frac_q, shd_frac_d;
  logic                 pending_q, pending_d;
  logic [CntW-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic [OsW-1:0]       os_cnt_q, os_cnt_d;
  logic                 os_tick_q, os_tick_d;
  logic                 bit_tick_q, bit_tick_d;

  logic                 apply;
  logic                 carry;
  logic                 wrap;
  logic [IntWidth-1:0]  div_eff;
  logic [CntW-1:0]      lim_last;

  // Apply decision uses the registered pending flag, so a write in the same
  // cycle never applies itself; it waits for the next idle cycle.
  assign apply = pending_q && !(rx_busy_i || tx_busy_i);

  // Divisors below 2 would need a tick every cycle; clamp to 2.
  assign div_eff  = (act_int_q < IntWidth'(2)) ? IntWidth'(2) : act_int_q;
  assign lim_last = {1'b0, div_eff} + {{IntWidth{1'b0}}, carry} - CntW'(1);
  assign wrap     = en_i && !apply && (cyc_cnt_q == lim_last);

  frac_accum #(
    .FracWidth (FracWidth)
  ) u_frac_accum (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (apply || !en_i),
    .wrap_i  (wrap),
    .frac_i  (act_frac_q),
    .carry_o (carry)
  );

  always_comb begin
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pending_d  = pending_q;
    cyc_cnt_d  = cyc_cnt_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;

    // Shadow side: the old shadow is what applies this cycle, a concurrent
    // write refills the shadow and keeps pending set.
    if (apply) begin
      act_int_d  = shd_int_q;
      act_frac_d = shd_frac_q;
      pending_d  = 1'b0;
    end
    if (div_wr_i) begin
      shd_int_d  = div_int_i;
      shd_frac_d = div_frac_i;
      pending_d  = 1'b1;
    end

    // Period engine: restart from phase zero on apply, hold while disabled.
    if (apply || !en_i) begin
      cyc_cnt_d = '0;
      os_cnt_d  = '0;
    end else if (wrap) begin
      cyc_cnt_d = '0;
      os_tick_d = 1'b1;
      if (os_cnt_q == OsLast) begin
        os_cnt_d   = '0;
        bit_tick_d = 1'b1;
      end else begin
        os_cnt_d = os_cnt_q + OsW'(1);
      end
    end else begin
      cyc_cnt_d = cyc_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_int_q  <= RstInt;
      act_frac_q <= RstFrac;
      shd_int_q  <= RstInt;
      shd_frac_q <= RstFrac;
      pending_q  <= 1'b0;
      cyc_cnt_q  <= '0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pending_q  <= pending_d;
      cyc_cnt_q  <= cyc_cnt_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign os_tick_o     = os_tick_q;
  assign bit_tick_o    = bit_tick_q;
  assign div_pending_o = pending_q;
  assign div_int_o     = act_int_q;
  assign div_frac_o    = act_frac_q;

endmodule
